// File: rtl/ssc_port_responder_if.sv
// SSC slave port plus register-bus signals for ssc_port_responder.
// Latency: none, this is only a signal bundle.
// Backpressure: none; the register bus is strobe-based with fixed read latency.
interface ssc_port_responder_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  sscClk;
  logic                  sscSync;
  logic                  sscDataIn;
  logic                  sscDataOut;
  logic [ADDR_WIDTH-1:0] regAddr;
  logic                  regWrEn;
  logic [DATA_WIDTH-1:0] regWrData;
  logic                  regRdEn;
  logic [DATA_WIDTH-1:0] regRdData;
  logic                  busy;
  logic                  frameErr;

  // Side that drives the serial lines and answers register reads.
  modport master (
    output sscClk, sscSync, sscDataIn, regRdData,
    input  sscDataOut, regAddr, regWrEn, regWrData, regRdEn, busy, frameErr
  );

  // The responder itself.
  modport slave (
    input  sscClk, sscSync, sscDataIn, regRdData,
    output sscDataOut, regAddr, regWrEn, regWrData, regRdEn, busy, frameErr
  );
endinterface

// File: rtl/ssc_port_responder.sv
// SSC slave that turns 8-bit command + DATA_WIDTH-bit data frames into register reads/writes.
// Latency: SYNC_STAGES+1 clk from an SSC pin edge to its effect; writes strobe 1 clk after sync release.
// Backpressure: none; clk must run at least 8x the SSC bit rate, register reads return 1 clk after regRdEn.
module ssc_port_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32
) (
  input logic                 clk,
  input logic                 rst,
  ssc_port_responder_if.slave bus
);

  localparam int CNT_W = $clog2(8 + DATA_WIDTH + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(8 + DATA_WIDTH);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(8 + DATA_WIDTH - 1);
  localparam logic [SET_W-1:0] SET_DONE  = SET_W'(SYNC_STAGES);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    WAIT_END
  } state_t;

  // Synchronizers (SYNC_STAGES must be at least 2) and edge history.
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_sync_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_clk_prev;
  logic                   r_sync_prev;
  logic [SET_W-1:0]       r_settle;
  logic                   r_armed;

  // FSM and datapath state.
  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [6:0]             r_cmd_shift;
  logic [DATA_WIDTH-1:0]  r_data_shift;
  logic                   r_dout;
  logic                   r_is_wr;
  logic                   r_long_err;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_wr_en;
  logic                   r_rd_en;
  logic                   r_rd_pend;
  logic                   r_err;

  // Decoded pin events.
  logic                   w_clk_s;
  logic                   w_sync_s;
  logic                   w_din;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_sync_fall;
  logic [7:0]             w_cmd;
  logic [ADDR_WIDTH-1:0]  w_addr_dec;

  // FSM control strobes.
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_shift_cmd;
  logic                   w_cmd_done;
  logic                   w_rd_start;
  logic                   w_shift_wdata;
  logic                   w_drive_bit;
  logic                   w_wr_issue;
  logic                   w_err;
  logic                   w_set_long;

  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_sync_s    = r_sync_sync[SYNC_STAGES-1];
  assign w_din       = r_din_sync[SYNC_STAGES-1];
  assign w_rise      = ~r_clk_prev & w_clk_s;
  assign w_fall      = r_clk_prev & ~w_clk_s;
  assign w_sync_fall = r_sync_prev & ~w_sync_s;

  // The completed command byte as seen on the 8th rising edge.
  assign w_cmd = {r_cmd_shift, w_din};

  // 7-bit command address zero-extended or truncated to the register address width.
  generate
    if (ADDR_WIDTH > 7) begin : g_addr_ext
      assign w_addr_dec = {{(ADDR_WIDTH-7){1'b0}}, w_cmd[6:0]};
    end else if (ADDR_WIDTH == 7) begin : g_addr_eq
      assign w_addr_dec = w_cmd[6:0];
    end else begin : g_addr_trunc
      assign w_addr_dec = w_cmd[ADDR_WIDTH-1:0];
    end
  endgenerate

  // Bring the SSC pins into the clk domain; flops rest at the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_sync_sync <= '1;
      r_din_sync  <= '1;
      r_clk_prev  <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.sscClk};
      r_sync_sync <= {r_sync_sync[SYNC_STAGES-2:0], bus.sscSync};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], bus.sscDataIn};
      r_clk_prev  <= w_clk_s;
      r_sync_prev <= w_sync_s;
    end
  end

  // After reset, only accept a frame once a genuine idle-high sync has been seen,
  // so a sync held low across reset cannot masquerade as a new frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SET_DONE) begin
        r_settle <= r_settle + SET_W'(1);
      end else if (w_sync_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control strobes; sync release always wins over a same-cycle clock edge.
  always_comb begin
    w_next_state  = r_state;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_shift_cmd   = 1'b0;
    w_cmd_done    = 1'b0;
    w_rd_start    = 1'b0;
    w_shift_wdata = 1'b0;
    w_drive_bit   = 1'b0;
    w_wr_issue    = 1'b0;
    w_err         = 1'b0;
    w_set_long    = 1'b0;
    case (r_state)
      IDLE: begin
        // Any clock edge coinciding with the frame start is dropped here.
        if (r_armed && w_sync_fall) begin
          w_next_state = CMD;
          w_cnt_clr    = 1'b1;
        end
      end
      CMD: begin
        if (w_sync_s) begin
          w_next_state = IDLE;
          w_err        = 1'b1;
        end else if (w_rise) begin
          w_shift_cmd = 1'b1;
          w_cnt_inc   = 1'b1;
          if (r_cnt == CMD_LAST) begin
            w_cmd_done = 1'b1;
            if (w_cmd[7]) begin
              w_next_state = WDATA;
            end else begin
              w_next_state = RDATA;
              w_rd_start   = 1'b1;
            end
          end
        end
      end
      WDATA: begin
        if (w_sync_s) begin
          w_next_state = IDLE;
          w_err        = 1'b1;
        end else if (w_rise) begin
          w_shift_wdata = 1'b1;
          w_cnt_inc     = 1'b1;
          if (r_cnt == DATA_LAST) begin
            w_next_state = WAIT_END;
          end
        end
      end
      RDATA: begin
        if (w_sync_s) begin
          w_next_state = IDLE;
          w_err        = 1'b1;
        end else begin
          if (w_rise) begin
            w_cnt_inc = 1'b1;
            if (r_cnt == DATA_LAST) begin
              w_next_state = WAIT_END;
            end
          end
          if (w_fall) begin
            w_drive_bit = 1'b1;
          end
        end
      end
      WAIT_END: begin
        if (w_sync_s) begin
          w_next_state = IDLE;
          w_wr_issue   = r_is_wr & ~r_long_err;
        end else if (w_rise && !r_long_err) begin
          w_err      = 1'b1;
          w_set_long = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Bit counter (saturating) and per-frame flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_long_err <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt      <= '0;
        r_is_wr    <= 1'b0;
        r_long_err <= 1'b0;
      end else begin
        if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_cmd_done) begin
          r_is_wr <= w_cmd[7];
        end
        if (w_set_long) begin
          r_long_err <= 1'b1;
        end
      end
    end
  end

  // Command and data shift registers; read data loads the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_shift  <= '0;
      r_data_shift <= '0;
      r_dout       <= 1'b0;
    end else begin
      if (w_shift_cmd) begin
        r_cmd_shift <= w_cmd[6:0];
      end
      if (r_rd_pend) begin
        r_data_shift <= bus.regRdData;
      end else if (w_shift_wdata) begin
        r_data_shift <= {r_data_shift[DATA_WIDTH-2:0], w_din};
      end else if (w_drive_bit) begin
        r_data_shift <= {r_data_shift[DATA_WIDTH-2:0], 1'b0};
      end
      if (w_cnt_clr) begin
        r_dout <= 1'b0;
      end else if (w_drive_bit) begin
        r_dout <= r_data_shift[DATA_WIDTH-1];
      end
    end
  end

  // Register-bus strobes; address and write data are held between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_cmd_done) begin
        r_addr <= w_addr_dec;
      end
      if (w_wr_issue) begin
        r_wr_data <= r_data_shift;
      end
      r_wr_en   <= w_wr_issue;
      r_rd_en   <= w_rd_start;
      r_rd_pend <= r_rd_en;
      r_err     <= w_err;
    end
  end

  assign bus.sscDataOut = (r_state == RDATA) & r_dout;
  assign bus.regAddr    = r_addr;
  assign bus.regWrEn    = r_wr_en;
  assign bus.regWrData  = r_wr_data;
  assign bus.regRdEn    = r_rd_en;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frameErr   = r_err;

endmodule

// File: tb/tb_ssc_port_responder.sv
// Bench for ssc_port_responder: frame table plus hand-written reset/idle/coincident-edge sequences.
// Expected register transactions are queued before each frame and popped when the DUT strobes.
module tb_ssc_port_responder;

  localparam int HALF = 6;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;
    int          nbits;
    bit          coin;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
  } vec_t;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk;
  logic rst;

  ssc_port_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

  ssc_port_responder #(
    .SYNC_STAGES(2),
    .ADDR_WIDTH (7),
    .DATA_WIDTH (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;

  wr_exp_t     wr_q[$];
  logic [6:0]  rd_q[$];
  logic [31:0] rdw_q[$];

  logic [31:0] rd_value = 32'h0;
  logic        rd_pend  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Register file model: data valid exactly one clk after regRdEn, noise otherwise.
  always @(negedge clk) begin
    bus.regRdData = rd_pend ? rd_value : $urandom;
    rd_pend = bus.regRdEn;
  end

  // Scoreboard side: compare every strobe the DUT produces against the queued expectations.
  always @(negedge clk) begin
    if (bus.regWrEn) begin
      wr_cnt++;
      chk("wr_expected", 64'(wr_q.size() > 0), 64'd1);
      if (wr_q.size() > 0) begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 64'(bus.regAddr), 64'(e.addr));
        chk("wr_data", 64'(bus.regWrData), 64'(e.data));
      end
    end
    if (bus.regRdEn) begin
      rd_cnt++;
      chk("rd_expected", 64'(rd_q.size() > 0), 64'd1);
      if (rd_q.size() > 0) begin
        logic [6:0] a;
        a = rd_q.pop_front();
        chk("rd_addr", 64'(bus.regAddr), 64'(a));
      end
    end
    if (bus.frameErr) err_cnt++;
  end

  task automatic ssc_half();
    repeat (HALF) @(negedge clk);
  endtask

  // Drives sync low and nbits SSC bits; samples sscDataOut just before each read-data rising edge.
  task automatic drive_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                             input bit coin, output logic [31:0] word);
    logic [39:0] frame;
    frame = {cmd, data};
    word = 32'h0;
    if (coin) begin
      bus.sscClk = 1'b0;
      ssc_half();
      bus.sscSync = 1'b0;
      bus.sscClk  = 1'b1;
      ssc_half();
    end else begin
      bus.sscSync = 1'b0;
      ssc_half();
    end
    for (int i = 0; i < nbits; i++) begin
      bus.sscClk    = 1'b0;
      bus.sscDataIn = (i < 40) ? frame[39-i] : 1'b0;
      ssc_half();
      if (i >= 8 && i < 40) word = {word[30:0], bus.sscDataOut};
      bus.sscClk = 1'b1;
      ssc_half();
    end
  endtask

  task automatic end_frame();
    bus.sscSync = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] word;
    int          w0, r0, e0;

    //          cmd     data          bits coin wr rd err
    vecs[0] = '{8'h85, 32'hDEADBEEF, 40, 1'b0, 1, 0, 0};  // basic write
    vecs[1] = '{8'h12, 32'h12345678, 40, 1'b0, 0, 1, 0};  // basic read
    vecs[2] = '{8'h85, 32'h0F0F1234, 20, 1'b0, 0, 0, 1};  // short write
    vecs[3] = '{8'h9A, 32'hCAFEF00D, 41, 1'b0, 0, 0, 1};  // long write
    vecs[4] = '{8'hFF, 32'h00000001, 40, 1'b0, 1, 0, 0};  // max address
    vecs[5] = '{8'h00, 32'hA5A55A5A, 40, 1'b0, 0, 1, 0};  // read address 0
    vecs[6] = '{8'h33, 32'h87654321, 12, 1'b0, 0, 1, 1};  // short read
    vecs[7] = '{8'h85, 32'h00000000,  4, 1'b0, 0, 0, 1};  // short in command
    vecs[8] = '{8'h84, 32'h11223344, 40, 1'b1, 1, 0, 0};  // clk edge with sync fall

    bus.sscClk    = 1'b1;
    bus.sscSync   = 1'b1;
    bus.sscDataIn = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_regAddr",    64'(bus.regAddr),    64'h0);
    chk("rst_regWrData",  64'(bus.regWrData),  64'h0);
    chk("rst_regWrEn",    64'(bus.regWrEn),    64'h0);
    chk("rst_regRdEn",    64'(bus.regRdEn),    64'h0);
    chk("rst_busy",       64'(bus.busy),       64'h0);
    chk("rst_frameErr",   64'(bus.frameErr),   64'h0);
    chk("rst_sscDataOut", 64'(bus.sscDataOut), 64'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      rd_value = vecs[k].data;
      if (vecs[k].exp_wr != 0) wr_q.push_back('{vecs[k].cmd[6:0], vecs[k].data});
      if (vecs[k].exp_rd != 0) rd_q.push_back(vecs[k].cmd[6:0]);
      if (vecs[k].exp_rd != 0 && vecs[k].nbits >= 40) rdw_q.push_back(vecs[k].data);
      drive_frame(vecs[k].cmd, vecs[k].data, vecs[k].nbits, vecs[k].coin, word);
      chk($sformatf("v%0d_busy_in_frame", k), 64'(bus.busy), 64'h1);
      end_frame();
      if (vecs[k].exp_rd != 0 && vecs[k].nbits >= 40)
        chk($sformatf("v%0d_read_word", k), 64'(word), 64'(rdw_q.pop_front()));
      chk($sformatf("v%0d_wr_strobes", k),  64'(wr_cnt - w0),  64'(vecs[k].exp_wr));
      chk($sformatf("v%0d_rd_strobes", k),  64'(rd_cnt - r0),  64'(vecs[k].exp_rd));
      chk($sformatf("v%0d_frame_errs", k),  64'(err_cnt - e0), 64'(vecs[k].exp_err));
      chk($sformatf("v%0d_busy_after", k),  64'(bus.busy),       64'h0);
      chk($sformatf("v%0d_dout_after", k),  64'(bus.sscDataOut), 64'h0);
    end

    // SSC clock toggling with sync high must be ignored.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    for (int t = 0; t < 10; t++) begin
      bus.sscClk = ~bus.sscClk;
      ssc_half();
      chk($sformatf("idle_dout_%0d", t), 64'(bus.sscDataOut), 64'h0);
    end
    bus.sscClk = 1'b1;
    ssc_half();
    chk("idle_busy",    64'(bus.busy),      64'h0);
    chk("idle_strobes", 64'(wr_cnt - w0 + rd_cnt - r0), 64'h0);
    chk("idle_errs",    64'(err_cnt - e0),  64'h0);

    // Reset in the middle of a write, then a clean write.
    w0 = wr_cnt; e0 = err_cnt;
    drive_frame(8'h85, 32'h11112222, 30, 1'b0, word);
    chk("mid_busy_before_rst", 64'(bus.busy), 64'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy",      64'(bus.busy),      64'h0);
    chk("mid_rst_regAddr",   64'(bus.regAddr),   64'h0);
    chk("mid_rst_regWrData", 64'(bus.regWrData), 64'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_stale_start", 64'(bus.busy), 64'h0);
    bus.sscSync = 1'b1;
    bus.sscClk  = 1'b1;
    repeat (10) @(negedge clk);
    wr_q.push_back('{7'h03, 32'h0000A5A5});
    drive_frame(8'h83, 32'h0000A5A5, 40, 1'b0, word);
    end_frame();
    chk("mid_wr_strobes", 64'(wr_cnt - w0),  64'h1);
    chk("mid_frame_errs", 64'(err_cnt - e0), 64'h0);
    chk("mid_regAddr",    64'(bus.regAddr),  64'h03);

    chk("wr_q_left",  64'(wr_q.size()),  64'h0);
    chk("rd_q_left",  64'(rd_q.size()),  64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
